// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared aluop and FSM state encodings for the bit-serial ALU
package alu_pkg;

  localparam logic [2:0] ALUOP_AND = 3'b000;
  localparam logic [2:0] ALUOP_OR  = 3'b001;
  localparam logic [2:0] ALUOP_ADD = 3'b010;
  localparam logic [2:0] ALUOP_NOR = 3'b100;
  localparam logic [2:0] ALUOP_SUB = 3'b110;
  localparam logic [2:0] ALUOP_SLT = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic is_addsub(input logic [2:0] op);
    return (op == ALUOP_ADD) || (op == ALUOP_SUB);
  endfunction

endpackage

// File: rtl/serial_alu_bit.sv
// rtl/serial_alu_bit.sv - one-bit ALU slice; SERIAL_ALU_NOR_EN enables the NOR opcode
module serial_alu_bit
  import alu_pkg::*;
(
  input  logic       ai,
  input  logic       bi,
  input  logic       ci,
  input  logic       binv,
  input  logic [2:0] op,
  output logic       ri,
  output logic       co
);

  logic bb;
  logic sum;

  assign bb  = bi ^ binv;
  assign sum = ai ^ bb ^ ci;
  assign co  = (ai & bb) | (ai & ci) | (bb & ci);

  always_comb begin
    ri = 1'b0;
    case (op)
      ALUOP_AND: ri = ai & bi;
      ALUOP_OR:  ri = ai | bi;
      ALUOP_ADD,
      ALUOP_SUB,
      ALUOP_SLT: ri = sum;
`ifdef SERIAL_ALU_NOR_EN
      ALUOP_NOR: ri = ~(ai | bi);
`endif
      default:   ri = 1'b0;
    endcase
  end

endmodule

// File: rtl/serial_alu.sv
// rtl/serial_alu.sv - bit-serial ALU, one bit per cycle LSB first, WIDTH+1 cycle latency
module serial_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       aluop,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [2:0]       op_r;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-2:0] sr;

  logic             ri;
  logic             co;
  logic [WIDTH-1:0] sr_full;
  logic [WIDTH-1:0] final_res;
  logic             final_ov;
  logic             last_bit;

  serial_alu_bit u_bit (
    .ai   (a_r[cnt]),
    .bi   (b_r[cnt]),
    .ci   (carry),
    .binv (op_r[2]),
    .op   (op_r),
    .ri   (ri),
    .co   (co)
  );

  // The current bit completes the word on the last RUN cycle, so sr only needs WIDTH-1 bits.
  assign sr_full  = {ri, sr};
  assign last_bit = (cnt == CNT_LAST);

  // On the last cycle carry holds carry-in(MSB) and co is carry-out(MSB).
  always_comb begin
    final_res = sr_full;
    final_ov  = 1'b0;
    if (op_r == ALUOP_SLT)
      final_res = {{(WIDTH-1){1'b0}}, ri ^ carry ^ co};
    if (is_addsub(op_r))
      final_ov = carry ^ co;
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      a_r      <= '0;
      b_r      <= '0;
      op_r     <= ALUOP_AND;
      cnt      <= '0;
      carry    <= 1'b0;
      sr       <= '0;
      result   <= '0;
      zero     <= 1'b1;
      overflow <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            a_r   <= a;
            b_r   <= b;
            op_r  <= aluop;
            cnt   <= '0;
            carry <= aluop[2];
            state <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          carry <= co;
          sr    <= sr_full[WIDTH-1:1];
          if (last_bit) begin
            cnt      <= '0;
            result   <= final_res;
            zero     <= ~|final_res;
            overflow <= final_ov;
            state    <= ST_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_alu.sv
// tb/tb_serial_alu.sv - self-checking bench for serial_alu against an arithmetic reference model
module tb_serial_alu;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   aluop;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         zero;
  logic         overflow;

  int vectors = 0;
  int miscompares = 0;

  logic [W-1:0] exp_res_last;
  logic         exp_zero_last;
  logic         exp_ov_last;

  serial_alu #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a        (a),
    .b        (b),
    .aluop    (aluop),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .zero     (zero),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Returns {overflow, result} from plain integer arithmetic.
  function automatic logic [W:0] ref_alu(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic [2:0] op);
    logic [W-1:0] r;
    logic         ov;
    r  = '0;
    ov = 1'b0;
    case (op)
      3'b000: r = x & y;
      3'b001: r = x | y;
      3'b010: begin
        r  = x + y;
        ov = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
      end
      3'b110: begin
        r  = x - y;
        ov = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
      end
      3'b111: r = ($signed(x) < $signed(y)) ? W'(1) : W'(0);
`ifdef SERIAL_ALU_NOR_EN
      3'b100: r = ~(x | y);
`endif
      default: r = '0;
    endcase
    return {ov, r};
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2:0] op,
                        input bit intrude);
    logic [W:0] m;
    m = ref_alu(x, y, op);
    start = 1'b1;
    a     = x;
    b     = y;
    aluop = op;
    @(posedge clk); #1;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    aluop = 3'($urandom_range(0, 7));
    check("busy_after_start", W'(busy), W'(1));
    check("done_after_start", W'(done), W'(0));
    for (int k = 1; k < W; k++) begin
      @(posedge clk); #1;
      check("busy_run", W'(busy), W'(1));
      check("done_run", W'(done), W'(0));
      check("result_held_run", result, exp_res_last);
      if (intrude && k == 9) begin
        start = 1'b1;
        a     = ~x;
        b     = ~y;
        aluop = 3'b110;
      end
      if (intrude && k == 10)
        start = 1'b0;
    end
    @(posedge clk); #1;
    check("done_pulse", W'(done), W'(1));
    check("busy_done", W'(busy), W'(0));
    check("result", result, m[W-1:0]);
    check("zero", W'(zero), W'(m[W-1:0] == '0));
    check("overflow", W'(overflow), W'(m[W]));
    exp_res_last  = m[W-1:0];
    exp_zero_last = (m[W-1:0] == '0);
    exp_ov_last   = m[W];
  endtask

  task automatic idle_check();
    @(posedge clk); #1;
    check("done_one_cycle", W'(done), W'(0));
    check("busy_idle", W'(busy), W'(0));
    check("result_held_idle", result, exp_res_last);
    check("zero_held_idle", W'(zero), W'(exp_zero_last));
    check("ov_held_idle", W'(overflow), W'(exp_ov_last));
  endtask

  initial begin
    logic [W-1:0] rx;
    logic [W-1:0] ry;
    logic [2:0]   rop;
    bit           chained;

    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    aluop = 3'b000;
    exp_res_last  = '0;
    exp_zero_last = 1'b1;
    exp_ov_last   = 1'b0;
    #2;
    check("reset_busy", W'(busy), W'(0));
    check("reset_done", W'(done), W'(0));
    check("reset_result", result, '0);
    check("reset_zero", W'(zero), W'(1));
    check("reset_overflow", W'(overflow), W'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    run_op(32'h0000_0005, 32'h0000_0003, 3'b010, 1'b0); idle_check();
    run_op(32'h8000_0000, 32'h0000_0001, 3'b110, 1'b0); idle_check();
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 3'b010, 1'b0); idle_check();
    run_op(32'h8000_0000, 32'h0000_0001, 3'b111, 1'b0); idle_check();
    run_op(32'h0000_0005, 32'h0000_0005, 3'b111, 1'b0); idle_check();
    run_op(32'h1234_5678, 32'h0000_1111, 3'b010, 1'b1); idle_check();

    // Reset during RUN: outputs clear at once and the abandoned op never signals done.
    start = 1'b1;
    a     = 32'hDEAD_BEEF;
    b     = 32'h0101_0101;
    aluop = 3'b010;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k < 16; k++) begin
      @(posedge clk); #1;
    end
    check("busy_before_reset", W'(busy), W'(1));
    reset = 1'b1;
    #1;
    check("busy_async_reset", W'(busy), W'(0));
    check("done_async_reset", W'(done), W'(0));
    check("result_async_reset", result, '0);
    check("zero_async_reset", W'(zero), W'(1));
    check("ov_async_reset", W'(overflow), W'(0));
    exp_res_last  = '0;
    exp_zero_last = 1'b1;
    exp_ov_last   = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < W + 3; k++) begin
      @(posedge clk); #1;
      check("no_done_after_reset", W'(done), W'(0));
      check("no_busy_after_reset", W'(busy), W'(0));
    end

    run_op(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b000, 1'b0); idle_check();

    // Back-to-back: start held in DONE goes straight to RUN.
    run_op(32'h0F0F_0000, 32'h00F0_00F0, 3'b001, 1'b0);
    run_op(32'h0000_0000, 32'h0000_0000, 3'b100, 1'b0);
    run_op(32'h0000_0009, 32'h0000_0007, 3'b011, 1'b0);
    idle_check();

    for (int n = 0; n < 30; n++) begin
      rx  = $urandom;
      ry  = $urandom;
      rop = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) ry = rx;
      if ($urandom_range(0, 3) == 0) rx = {1'b1, 31'($urandom_range(0, 3))};
      chained = ($urandom_range(0, 1) == 1);
      run_op(rx, ry, rop, 1'b0);
      if (!chained) idle_check();
    end
    idle_check();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
